// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands.
// Optional ovf output enabled by defining BOOTH_NARROW_OVF_EN.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
`ifdef BOOTH_NARROW_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand;
  logic [QW-1:0]   mq;
  logic            q_1;
  logic            smode;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]        sum;
  logic [AW-1:0]        nxt_acc;
  logic [QW-1:0]        nxt_q;
  logic [2*WIDTH-1:0]   nxt_prod;

  always_comb begin
    sum = acc;
    unique case ({mq[0], q_1})
      2'b10:   sum = acc - mcand;
      2'b01:   sum = acc + mcand;
      default: sum = acc;
    endcase
    nxt_acc = {sum[AW-1], sum[AW-1:1]};
    nxt_q   = {sum[0], mq[QW-1:1]};
    // Signed runs one step fewer, so the product sits one bit higher.
    if (smode)
      nxt_prod = {nxt_acc[WIDTH-1:0], nxt_q[QW-1:1]};
    else
      nxt_prod = {nxt_acc[WIDTH-2:0], nxt_q};
  end

`ifdef BOOTH_NARROW_OVF_EN
  logic nxt_ovf;
  logic [WIDTH:0] hi_s;
  logic [WIDTH-1:0] hi_u;

  assign hi_s = nxt_prod[2*WIDTH-1:WIDTH-1];
  assign hi_u = nxt_prod[2*WIDTH-1:WIDTH];
  assign nxt_ovf = smode ? ~((&hi_s) | ~(|hi_s))
                         : |hi_u;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mq      <= '0;
      q_1     <= 1'b0;
      smode   <= 1'b0;
      cnt     <= '0;
`ifdef BOOTH_NARROW_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= '0;
            q_1   <= 1'b0;
            smode <= signed_mode;
            if (signed_mode) begin
              mq    <= {a[WIDTH-1], a};
              mcand <= {{2{b[WIDTH-1]}}, b};
              cnt   <= CW'(WIDTH);
            end else begin
              mq    <= {1'b0, a};
              mcand <= {2'b00, b};
              cnt   <= CW'(WIDTH + 1);
            end
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= nxt_acc;
          mq  <= nxt_q;
          q_1 <= mq[0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= nxt_prod;
`ifdef BOOTH_NARROW_OVF_EN
            ovf     <= nxt_ovf;
`endif
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 signed_mode  input  1  1 means two's-complement operands, 0 means unsigned; captured with start.
REQ-006 a  input  WIDTH  multiplier; captured with start.
REQ-007 b  input  WIDTH  multiplicand; captured with start.
REQ-008 busy  output  1  high while a multiplication is in progress (RUN state).
REQ-009 done  output  1  single-cycle pulse marking product valid.
REQ-010 product  output  2*WIDTH  result; two's-complement in signed mode, unsigned otherwise.
REQ-011 ovf  output  1  narrow-overflow flag; present only with BOOTH_NARROW_OVF_EN (REQ-030).

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after the last iteration.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 Acceptance SHALL capture a, b and signed_mode into internal registers in IDLE with start=1; later operand changes SHALL NOT affect the result.
REQ-014 The block SHALL ignore start while busy=1 or in DONE, with no queuing.
REQ-015 Each RUN cycle SHALL perform exactly one radix-2 Booth step. The step examines the pair (Q[0], q_1):
- 00 or 11: arithmetic shift only.
- 10: A-M, then shift.
- 01: A+M, then shift.
The shift is an arithmetic right shift of {A,Q,q_1}.
REQ-016 Signed mode SHALL run N=WIDTH iterations on sign-extended operands.
REQ-017 Unsigned mode SHALL zero-extend both operands to WIDTH+1 bits and run N=WIDTH+1 iterations.
REQ-018 The accumulator SHALL be WIDTH+2 bits wide; no intermediate overflow is permitted for any operand pair, including the most-negative value times itself.
REQ-019 An iteration counter SHALL load N on acceptance and decrement once per RUN cycle; the FSM SHALL leave RUN when the counter reaches 1.
REQ-020 Latency: done SHALL be high in exactly the cycle following N+1 rising edges after the edge that sampled start.
- Signed, WIDTH=8: 9 cycles.
- Unsigned, WIDTH=8: 10 cycles.
REQ-021 product SHALL update only when entering DONE and SHALL hold its value until the next entry to DONE, including through IDLE.
REQ-022 busy SHALL be 1 exactly in RUN cycles; done SHALL be 1 exactly in the DONE cycle; the two SHALL never be high together.
REQ-023 Back-to-back throughput: a start presented in the first IDLE cycle after DONE SHALL be accepted, giving one result per N+2 cycles.
REQ-024 The result SHALL equal the exact mathematical product for every operand pair in both modes.

Reset
REQ-025 With rst_n=0 at a rising edge, the block SHALL enter IDLE and clear busy, done, product, ovf, the counter and all datapath registers to 0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the discarded result SHALL never appear on product.
REQ-027 start SHALL be ignored in any cycle where rst_n=0.
REQ-028 The first start SHALL be accepted at the first rising edge with rst_n=1.

Configuration
REQ-029 Macro BOOTH_NARROW_OVF_EN controls the ovf output.
REQ-030 With BOOTH_NARROW_OVF_EN defined, port ovf SHALL exist and update together with product. ovf=1 when the product does not fit in WIDTH bits:
- signed mode: product outside [-2^(WIDTH-1), 2^(WIDTH-1)-1];
- unsigned mode: product >= 2^WIDTH.
REQ-031 Without the macro, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-032 Signed, a=-128 (0x80), b=-128 -> product=0x4000 after 9 cycles; done pulses once; ovf=1.
REQ-033 Signed, a=127, b=-1 -> product=0xFF81; ovf=0. Unsigned, a=255, b=255 -> product=0xFE01 after 10 cycles; ovf=1.
REQ-034 Signed, a=16, b=16 with start held high continuously -> product=0x0100 and ovf=1. A second result follows exactly N+2 cycles after the first done, and no start is accepted while busy.
REQ-035 Change a, b and signed_mode every cycle during RUN after accepting signed 3 x -5 -> product=0xFFF1; inputs are not re-sampled.
REQ-036 Set rst_n=0 at RUN iteration 4 of 100 x 100, prior product 0x0006 -> no done pulse; product=0; the next operation 0 x -7 returns 0x0000.
REQ-037 Randomised sweep of 10,000 operand pairs in both modes against a reference model -> zero mismatches.
